// File: rtl/regfile_op_sequencer_pkg.sv
// Shared widths and state encodings for the register-file operation sequencer.
package regfile_op_sequencer_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned SEL_W_DEF  = 4;
    localparam int unsigned STATE_W    = 4;

    localparam logic [STATE_W-1:0] S_IDLE = 4'b0000;
    localparam logic [STATE_W-1:0] S_RD_B = 4'b0001;
    localparam logic [STATE_W-1:0] S_RD_C = 4'b0010;
    localparam logic [STATE_W-1:0] S_EXEC = 4'b0011;
    localparam logic [STATE_W-1:0] S_WAIT = 4'b0100;
    localparam logic [STATE_W-1:0] S_WB   = 4'b0101;
    localparam logic [STATE_W-1:0] S_DONE = 4'b0110;

endpackage

// File: rtl/register_32.sv
// Holding register with async active-low clear and load enable.
module register_32 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] D,
    input  logic         clr,
    input  logic         clk,
    input  logic         write,
    output logic [W-1:0] Q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q <= '0;
        end else if (write) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one ra <= rb op (rc|imm) transfer through a single-read-port
// register file and an external ALU.
module regfile_op_sequencer
    import regfile_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SEL_W  = SEL_W_DEF
) (
    input  logic              in_clk,
    input  logic              in_clr,
    input  logic              in_start,
    input  logic [SEL_W-1:0]  in_ra,
    input  logic [SEL_W-1:0]  in_rb,
    input  logic [SEL_W-1:0]  in_rc,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_nowb,
    output logic              out_busy,
    output logic              out_done,
    output logic [SEL_W-1:0]  out_Aselect,
    input  logic [DATA_W-1:0] in_Adata,
    output logic [SEL_W-1:0]  out_Cselect,
    output logic [DATA_W-1:0] out_Cdata,
    output logic              out_write,
    output logic [DATA_W-1:0] out_opA,
    output logic [DATA_W-1:0] out_opB,
    output logic              out_alu_go,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_alu_valid
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;

    logic [SEL_W-1:0]   ra_q;
    logic [SEL_W-1:0]   rb_q;
    logic [SEL_W-1:0]   rc_q;
    logic [DATA_W-1:0]  imm_q;
    logic               use_imm_q;
    logic               nowb_q;

    logic               accept;
    logic               opa_wr;
    logic               opb_wr;
    logic               res_wr;
    logic [DATA_W-1:0]  opb_d;
    logic [DATA_W-1:0]  result_q;

    logic               busy_nxt;
    logic               done_nxt;
    logic               write_nxt;
    logic               alu_go_nxt;
    logic [SEL_W-1:0]   asel_nxt;

    // Next-state, holding-register enables and next output values.
    always_comb begin
        state_nxt  = state_q;
        accept     = 1'b0;
        opa_wr     = 1'b0;
        opb_wr     = 1'b0;
        res_wr     = 1'b0;
        opb_d      = imm_q;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    accept    = 1'b1;
                    state_nxt = S_RD_B;
                end
            end
            S_RD_B: begin
                opa_wr = 1'b1;
                if (use_imm_q) begin
                    opb_wr    = 1'b1;
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_RD_C;
                end
            end
            S_RD_C: begin
                opb_wr    = 1'b1;
                opb_d     = in_Adata;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (in_alu_valid) begin
                    res_wr    = 1'b1;
                    state_nxt = nowb_q ? S_DONE : S_WB;
                end
            end
            S_WB: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track the state register exactly.
        busy_nxt   = (state_nxt != S_IDLE);
        done_nxt   = (state_nxt == S_DONE);
        write_nxt  = (state_nxt == S_WB);
        alu_go_nxt = (state_nxt == S_EXEC);
        asel_nxt   = '0;
        // S_RD_B is only ever entered from an accepted start, so rb comes straight from the port.
        if (state_nxt == S_RD_B) begin
            asel_nxt = in_rb;
        end else if (state_nxt == S_RD_C) begin
            asel_nxt = rc_q;
        end
    end

    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Operation fields captured once per accepted start.
    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            nowb_q    <= 1'b0;
        end else if (accept) begin
            ra_q      <= in_ra;
            rb_q      <= in_rb;
            rc_q      <= in_rc;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
            nowb_q    <= in_nowb;
        end
    end

    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            out_busy    <= 1'b0;
            out_done    <= 1'b0;
            out_write   <= 1'b0;
            out_alu_go  <= 1'b0;
            out_Aselect <= '0;
        end else begin
            out_busy    <= busy_nxt;
            out_done    <= done_nxt;
            out_write   <= write_nxt;
            out_alu_go  <= alu_go_nxt;
            out_Aselect <= asel_nxt;
        end
    end

    register_32 #(.W(DATA_W)) u_opa (
        .D     (in_Adata),
        .clr   (in_clr),
        .clk   (in_clk),
        .write (opa_wr),
        .Q     (out_opA)
    );

    register_32 #(.W(DATA_W)) u_opb (
        .D     (opb_d),
        .clr   (in_clr),
        .clk   (in_clk),
        .write (opb_wr),
        .Q     (out_opB)
    );

    register_32 #(.W(DATA_W)) u_result (
        .D     (in_alu_result),
        .clr   (in_clr),
        .clk   (in_clk),
        .write (res_wr),
        .Q     (result_q)
    );

    assign out_Cselect = ra_q;
    assign out_Cdata   = result_q;

endmodule
